// File: rtl/nes_clk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nes_clk_pkg
// Description : Shared state encoding and NES divider ratios for the core
//               clock-enable generator.
// Revision    : 1.0 - initial release
// ============================================================================
package nes_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    // Divider ratios expressed in master ticks
    localparam int PPU_DIV_NTSC = 4;
    localparam int PPU_DIV_PAL  = 5;
    localparam int CPU_DIV_NTSC = 12;
    localparam int CPU_DIV_PAL  = 16;

    function automatic logic [2:0] ppu_last(input logic pal_mode);
        return pal_mode ? 3'(PPU_DIV_PAL - 1) : 3'(PPU_DIV_NTSC - 1);
    endfunction

    function automatic logic [3:0] cpu_last(input logic pal_mode);
        return pal_mode ? 4'(CPU_DIV_PAL - 1) : 4'(CPU_DIV_NTSC - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nes_lock_sync.sv
`default_nettype none
// ============================================================================
// Module      : nes_lock_sync
// Description : Two-flop synchroniser bringing the PLL lock into clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module nes_lock_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic [1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_async};
        end
    end

    assign o_sync = r_sync[1];

endmodule
`default_nettype wire

// File: rtl/nes_clk_ce_gen.sv
`default_nettype none
// ============================================================================
// Module      : nes_clk_ce_gen
// Description : PLL lock qualification, core reset sequencing and NES
//               master/PPU/CPU clock enables (NTSC/PAL) with aligned pause.
//               Optional cpu_cycles counter: NES_CLK_CE_GEN_CYCLE_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module nes_clk_ce_gen
    import nes_clk_pkg::*;
#(
    parameter int HOLD_CYCLES = 1024,
    parameter int MASTER_DIV  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pll_locked,
    input  logic        pal,
    input  logic        pause,
    output logic        sys_reset,
    output logic        ce_master,
    output logic        ce_ppu,
    output logic        ce_cpu,
    output logic        paused
`ifdef NES_CLK_CE_GEN_CYCLE_CNT_EN
    ,
    output logic [31:0] cpu_cycles
`endif
);

    localparam int                 c_P_W       = (MASTER_DIV > 2) ? $clog2(MASTER_DIV) : 1;
    localparam logic [c_P_W-1:0]   c_P_LAST    = c_P_W'(MASTER_DIV - 1);
    localparam logic [c_P_W-1:0]   c_P_PRE     = c_P_W'(MASTER_DIV - 2);
    localparam logic [15:0]        c_HOLD_LAST = 16'(HOLD_CYCLES - 1);

    logic             w_lock_s;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_hold_cnt;
    logic [c_P_W-1:0] r_p;
    logic [2:0]       r_ppu_cnt;
    logic [3:0]       r_cpu_cnt;
    logic             r_pal_mode;
    logic             r_paused;
    logic             r_sys_reset;
    logic             r_ce_master;
    logic             r_ce_ppu;
    logic             r_ce_cpu;

    logic             w_run_next;
    logic             w_tick;
    logic             w_ppu_wrap;
    logic             w_cpu_wrap;
    logic             w_align;
    logic             w_pause_enter;
    logic             w_ce_ppu_nxt;
    logic             w_ce_cpu_nxt;

    nes_lock_sync u_lock_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (pll_locked),
        .o_sync  (w_lock_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= WAIT_LOCK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WAIT_LOCK: if (w_lock_s) w_state_nxt = HOLD;
            HOLD: begin
                if (!w_lock_s) begin
                    w_state_nxt = WAIT_LOCK;
                end else if (r_hold_cnt == c_HOLD_LAST) begin
                    w_state_nxt = RUN;
                end
            end
            RUN:       if (!w_lock_s) w_state_nxt = WAIT_LOCK;
            default:   w_state_nxt = WAIT_LOCK;
        endcase
    end

    // Outputs are registered, so every enable is decided one cycle ahead:
    // a tick is flagged in the cycle before the prescaler reaches its last value.
    always_comb begin
        w_run_next    = (r_state == RUN) && (w_state_nxt == RUN);
        w_tick        = w_run_next && (r_p == c_P_PRE);
        w_ppu_wrap    = (r_ppu_cnt == ppu_last(r_pal_mode));
        w_cpu_wrap    = (r_cpu_cnt == cpu_last(r_pal_mode));
        w_align       = w_tick && !r_paused && w_ppu_wrap && w_cpu_wrap;
        w_pause_enter = w_align && pause && !r_sys_reset;
        w_ce_ppu_nxt  = w_tick && !r_paused && w_ppu_wrap && !w_pause_enter;
        w_ce_cpu_nxt  = w_tick && !r_paused && w_cpu_wrap && !w_pause_enter;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_cnt  <= '0;
            r_p         <= '0;
            r_ppu_cnt   <= '0;
            r_cpu_cnt   <= '0;
            r_pal_mode  <= 1'b0;
            r_paused    <= 1'b0;
            r_sys_reset <= 1'b1;
            r_ce_master <= 1'b0;
            r_ce_ppu    <= 1'b0;
            r_ce_cpu    <= 1'b0;
        end else begin
            r_sys_reset <= (w_state_nxt != RUN);
            r_ce_master <= w_tick;
            r_ce_ppu    <= w_ce_ppu_nxt;
            r_ce_cpu    <= w_ce_cpu_nxt;

            if ((r_state == HOLD) && (w_state_nxt == HOLD)) begin
                r_hold_cnt <= r_hold_cnt + 16'd1;
            end else begin
                r_hold_cnt <= '0;
            end

            if (!w_run_next) begin
                r_p       <= '0;
                r_ppu_cnt <= '0;
                r_cpu_cnt <= '0;
                r_paused  <= 1'b0;
            end else begin
                r_p <= (r_p == c_P_LAST) ? '0 : r_p + 1'b1;
                if (w_tick) begin
                    if (r_paused) begin
                        // Counters stay at 0 through the release tick so the
                        // first CPU period after a pause is a full one.
                        if (!pause) r_paused <= 1'b0;
                    end else begin
                        r_ppu_cnt <= w_ppu_wrap ? 3'd0 : r_ppu_cnt + 3'd1;
                        r_cpu_cnt <= w_cpu_wrap ? 4'd0 : r_cpu_cnt + 4'd1;
                        if (w_align) begin
                            r_pal_mode <= pal;
                            if (w_pause_enter) r_paused <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign sys_reset = r_sys_reset;
    assign ce_master = r_ce_master;
    assign ce_ppu    = r_ce_ppu;
    assign ce_cpu    = r_ce_cpu;
    assign paused    = r_paused;

`ifdef NES_CLK_CE_GEN_CYCLE_CNT_EN
    logic [31:0] r_cpu_cycles;

    // Advances on the same edge that raises ce_cpu; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpu_cycles <= '0;
        end else if (r_sys_reset) begin
            r_cpu_cycles <= '0;
        end else if (w_ce_cpu_nxt) begin
            r_cpu_cycles <= r_cpu_cycles + 32'd1;
        end
    end

    assign cpu_cycles = r_cpu_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nes_clk_ce_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_nes_clk_ce_gen
// Description : Directed self-checking bench for nes_clk_ce_gen (HOLD_CYCLES=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nes_clk_ce_gen;

    logic clk = 1'b0;
    logic reset, pll_locked, pal, pause;
    logic sys_reset, ce_master, ce_ppu, ce_cpu, paused;
`ifdef NES_CLK_CE_GEN_CYCLE_CNT_EN
    logic [31:0] cpu_cycles;
`endif

    int total = 0;
    int bad   = 0;
    int idx   = 0;

    int nm, np, nc, orphan, wide, leak, fm, first_pause, last_paused;
    int qp[$];
    int qc[$];

    nes_clk_ce_gen #(.HOLD_CYCLES(16), .MASTER_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .pll_locked (pll_locked),
        .pal        (pal),
        .pause      (pause),
        .sys_reset  (sys_reset),
        .ce_master  (ce_master),
        .ce_ppu     (ce_ppu),
        .ce_cpu     (ce_cpu),
        .paused     (paused)
`ifdef NES_CLK_CE_GEN_CYCLE_CNT_EN
        ,
        .cpu_cycles (cpu_cycles)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        idx++;
    endtask

    // Counts clk edges until sys_reset drops; RUN cycle index 0 is then idx=0.
    task automatic wait_run(output int n);
        n = 0;
        while (sys_reset !== 1'b0 && n < 200) begin
            step();
            n++;
        end
        idx = 0;
    endtask

    // Samples the current cycle through cycle 'last' inclusive.
    task automatic run_until(input int last);
        logic pm, pp, pc;
        nm = 0; np = 0; nc = 0; orphan = 0; wide = 0; leak = 0;
        fm = -1; first_pause = -1; last_paused = -1;
        qp.delete();
        qc.delete();
        pm = 1'b0; pp = 1'b0; pc = 1'b0;
        forever begin
            if (ce_master === 1'b1) begin
                nm++;
                if (fm < 0) fm = idx;
                if (pm) wide++;
            end
            if (ce_ppu === 1'b1) begin
                np++;
                qp.push_back(idx);
                if (pp) wide++;
            end
            if (ce_cpu === 1'b1) begin
                nc++;
                qc.push_back(idx);
                if (ce_ppu !== 1'b1) orphan++;
                if (pc) wide++;
            end
            if (paused === 1'b1) begin
                if (first_pause < 0) first_pause = idx;
                last_paused = idx;
                if (ce_ppu === 1'b1 || ce_cpu === 1'b1) leak++;
            end
            pm = ce_master; pp = ce_ppu; pc = ce_cpu;
            if (idx >= last) break;
            step();
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    initial begin
        int n;
        reset = 1'b1; pll_locked = 1'b0; pal = 1'b0; pause = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sys_reset", 32'(sys_reset), 1);
        chk("rst_ce", 32'({ce_master, ce_ppu, ce_cpu}), 0);
        chk("rst_paused", 32'(paused), 0);
        reset = 1'b0;
        repeat (4) step();
        chk("no_lock_sys_reset", 32'(sys_reset), 1);

        // Lock: counted from the first edge that samples pll_locked high,
        // 2 sync + 16 hold cycles, so sys_reset is low after the 19th edge.
        pll_locked = 1'b1;
        wait_run(n);
        chk("lock_to_run", n, 19);

        // NTSC steady state over RUN indices 0..479
        run_until(479);
        chk("first_master", fm, 3);
        chk("first_ppu", qget(qp, 0), 15);
        chk("first_cpu", qget(qc, 0), 47);
        chk("ntsc_nm", nm, 120);
        chk("ntsc_np", np, 30);
        chk("ntsc_nc", nc, 10);
        chk("ntsc_orphan_cpu", orphan, 0);
        chk("ntsc_wide", wide, 0);

        // Pause 10 clk after align 479; honoured at align 527
        run_until(489);
        pause = 1'b1;
        run_until(526);
        chk("pre_pause_np", np, 2);
        chk("pre_pause_nc", nc, 0);
        chk("pre_pause_paused", first_pause, -1);
        run_until(599);
        chk("pause_start", first_pause, 527);
        chk("paused_np", np, 0);
        chk("paused_nc", nc, 0);
        chk("paused_nm", nm, 19);
        pause = 1'b0;
        run_until(700);
        chk("pause_end", last_paused, 602);
        chk("unpause_first_ppu", qget(qp, 0), 619);
        chk("unpause_first_cpu", qget(qc, 0), 651);
        chk("unpause_leak", leak, 0);

        // PAL requested mid-period; switch at align 747
        run_until(710);
        pal = 1'b1;
        run_until(1067);
        chk("pal_ppu0", qget(qp, 0), 715);
        chk("pal_ppu2", qget(qp, 2), 747);
        chk("pal_ppu3", qget(qp, 3), 767);
        chk("pal_ppu4", qget(qp, 4), 787);
        chk("pal_cpu0", qget(qc, 0), 747);
        chk("pal_cpu1", qget(qc, 1), 811);
        chk("pal_cpu2", qget(qc, 2), 875);
        chk("pal_np", np, 19);
        chk("pal_nc", nc, 6);
        chk("pal_wide", wide, 0);

        // Lock loss during RUN
        run_until(1080);
        pll_locked = 1'b0;
        n = 0;
        while (sys_reset !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("drop_latency", n, 3);
        run_until(idx + 10);
        chk("drop_ce_quiet", nm + np + nc, 0);

        // Lock glitch mid-HOLD, then a clean relock restarts HOLD from 0
        pll_locked = 1'b1;
        repeat (10) step();
        pll_locked = 1'b0;
        repeat (5) step();
        chk("glitch_sys_reset", 32'(sys_reset), 1);
        pll_locked = 1'b1;
        wait_run(n);
        chk("relock_to_run", n, 19);

        // Asynchronous reset while paused restores reset values and NTSC
        pause = 1'b1;
        n = 0;
        while (paused !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        chk("pause_reached", 32'(paused), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_sys_reset", 32'(sys_reset), 1);
        chk("async_ce", 32'({ce_master, ce_ppu, ce_cpu}), 0);
        chk("async_paused", 32'(paused), 0);
        pause = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        wait_run(n);
        chk("post_reset_run", n, 19);
        run_until(47);
        chk("post_reset_ppu", qget(qp, 0), 15);
        chk("post_reset_cpu", qget(qc, 0), 47);

`ifdef NES_CLK_CE_GEN_CYCLE_CNT_EN
        begin
            int c, pz, guard;
            bit done_pause;
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            wait_run(n);
            chk("cyc_cleared", cpu_cycles, 0);
            c = 0; pz = 0; guard = 0; done_pause = 1'b0;
            while (c < 100 && guard < 20000) begin
                step();
                guard++;
                if (ce_cpu === 1'b1) c++;
                if (c == 50 && !done_pause) pause = 1'b1;
                if (paused === 1'b1) begin
                    pz++;
                    if (pz == 20) begin
                        pause = 1'b0;
                        done_pause = 1'b1;
                    end
                end
            end
            chk("cyc_seen_pause", 32'(pz >= 20), 1);
            chk("cyc_count", cpu_cycles, 100);
            force dut.r_cpu_cycles = 32'hFFFF_FFFF;
            #1;
            release dut.r_cpu_cycles;
            step();
            chk("cyc_forced", cpu_cycles, 32'hFFFF_FFFF);
            guard = 0;
            while (ce_cpu !== 1'b1 && guard < 100) begin
                step();
                guard++;
            end
            chk("cyc_wrap", cpu_cycles, 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
